product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator/result width; legal range 8..32.
REQ-002 SHALL have parameter COUNT, default 4, products summed per group; legal range 1..255.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port io_in_valid  input  1  upstream 4x4 multiplier product valid.
REQ-006 SHALL have port io_in_ready  output  1  block accepts a product this cycle.
REQ-007 SHALL have port io_in_product  input  8  unsigned product from the upstream multiplier stage.
REQ-008 SHALL have port io_clear  input  1  synchronous abort of the current group.
REQ-009 SHALL have port io_out_valid  output  1  group sum valid.
REQ-010 SHALL have port io_out_ready  input  1  downstream accepts the sum.
REQ-011 SHALL have port io_out_sum  output  ACC_W  unsigned group sum.
REQ-012 SHALL have port io_out_overflow  output  1  sum exceeded 2^ACC_W-1 at some point in the group.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-014 In ACCUM: io_in_ready=1, io_out_valid=0; input fire = io_in_valid & io_in_ready.
REQ-015 On input fire: acc <= acc + zero-extended product (ACC_W+1-bit add); cnt <= cnt+1; overflow flag sticky-set on carry out of bit ACC_W-1.
REQ-016 On the fire where cnt==COUNT-1: FSM -> HOLD; io_out_valid=1 from the next cycle (1-cycle latency from last product to result).
REQ-017 In HOLD: io_in_ready=0, io_out_valid=1, io_out_sum=acc, io_out_overflow=flag, all held stable until output fire.
REQ-018 On output fire (io_out_valid & io_out_ready): acc, cnt, flag <= 0; FSM -> ACCUM; io_in_ready=1 next cycle (no same-cycle accept).
REQ-019 io_clear=1 in any state: acc, cnt, flag <= 0, FSM -> ACCUM next cycle; clear wins over simultaneous input or output fire (product discarded, result dropped).
REQ-020 io_in_ready SHALL NOT depend combinationally on io_in_valid; io_out_valid SHALL NOT depend on io_out_ready.
REQ-021 With COUNT=1 every accepted product SHALL produce one result.
REQ-022 io_out_sum and io_out_overflow SHALL read 0 whenever io_out_valid=0.

Reset
REQ-023 While reset=1: FSM=ACCUM, acc=0, cnt=0, flag=0; io_out_valid=0, io_out_sum=0, io_out_overflow=0, io_in_ready=0.
REQ-024 reset mid-group or in HOLD SHALL discard partial/held results; io_in_ready=1 the first cycle after reset deasserts.
REQ-025 reset SHALL take priority over io_clear and all handshakes.

Configuration
REQ-026 Macro PRODUCT_ACCUMULATOR_SAT_EN defined: on carry out, acc SHALL saturate to 2^ACC_W-1 and remain there for the rest of the group; flag set.
REQ-027 Macro undefined: acc SHALL wrap modulo 2^ACC_W; flag set identically.

Verification
REQ-028 ACC_W=12, COUNT=4, four products 225 back-to-back, io_out_ready=1 -> io_out_valid one cycle after 4th fire, io_out_sum=900, overflow=0, io_in_ready=1 the cycle after.
REQ-029 ACC_W=9, COUNT=4, four products 225 -> without SAT_EN sum=388, overflow=1; with SAT_EN sum=511, overflow=1.
REQ-030 Results 3,5 with io_out_ready=0 for 5 cycles in HOLD -> sum=8 held stable, io_in_ready=0, io_in_valid ignored; released on ready.
REQ-031 Two products (10,20), then io_clear together with valid product 30 -> next group 1,1,1,1 yields sum=4, overflow=0.
REQ-032 reset asserted in HOLD with sum=900 -> io_out_valid=0, io_out_sum=0 next cycle; following group 2,2,2,2 yields 8.
REQ-033 COUNT=1, products 0 and 255 with gaps in io_in_valid -> two results 0 and 255, each one cycle after its accept.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products per group and hands the sum downstream over a valid/ready pair.
// Optional macro PRODUCT_ACCUMULATOR_SAT_EN: saturate the sum on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [7:0]       io_in_product,
  input  logic             io_clear,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [ACC_W-1:0] io_out_sum,
  output logic             io_out_overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [ACC_W:0]   add_s;
  logic             carry_s;
  logic             in_fire_s;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    add_s     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, io_in_product};
    carry_s   = add_s[ACC_W];
    in_fire_s = io_in_valid & (state_q == ACCUM);

    // Clear outranks any handshake in the same cycle: product discarded, held result dropped.
    if (io_clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = 8'd0;
      flag_d  = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_fire_s) begin
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
            if (carry_s || flag_q) begin
              acc_d = '1;
            end else begin
              acc_d = add_s[ACC_W-1:0];
            end
`else
            acc_d = add_s[ACC_W-1:0];
`endif
            flag_d = flag_q | carry_s;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
              state_d = HOLD;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (io_out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = 8'd0;
            flag_d  = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = 8'd0;
          flag_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Handshake outputs are masked while reset is held so nothing is offered or accepted.
  assign io_in_ready     = ~reset & (state_q == ACCUM);
  assign io_out_valid    = ~reset & (state_q == HOLD);
  assign io_out_sum      = io_out_valid ? acc_q : '0;
  assign io_out_overflow = io_out_valid & flag_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised and directed bench for product_accumulator: three instances share the stimulus and are
// compared every cycle against an exact-integer group model.
module tb_product_accumulator;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_product;
  logic        clear;
  logic        out_ready;

  logic        rdy [3];
  logic        vld [3];
  logic        ovf [3];
  logic [31:0] act_sum [3];
  logic [11:0] s0;
  logic [8:0]  s1;
  logic [11:0] s2;

  int total = 0;
  int bad   = 0;

  // Model state per instance: exact (unbounded) running sum, products taken, result held.
  int m_exact [3];
  int m_cnt   [3];
  bit m_hold  [3];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  product_accumulator #(.ACC_W(12), .COUNT(4)) dut0 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rdy[0]),
    .io_in_product(in_product), .io_clear(clear), .io_out_valid(vld[0]),
    .io_out_ready(out_ready), .io_out_sum(s0), .io_out_overflow(ovf[0]));
  product_accumulator #(.ACC_W(9), .COUNT(4)) dut1 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rdy[1]),
    .io_in_product(in_product), .io_clear(clear), .io_out_valid(vld[1]),
    .io_out_ready(out_ready), .io_out_sum(s1), .io_out_overflow(ovf[1]));
  product_accumulator #(.ACC_W(12), .COUNT(1)) dut2 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rdy[2]),
    .io_in_product(in_product), .io_clear(clear), .io_out_valid(vld[2]),
    .io_out_ready(out_ready), .io_out_sum(s2), .io_out_overflow(ovf[2]));

  assign act_sum[0] = 32'(s0);
  assign act_sum[1] = 32'(s1);
  assign act_sum[2] = 32'(s2);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int acc_w(input int i);
    return (i == 1) ? 9 : 12;
  endfunction

  function automatic int count_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int exp_sum(input int i);
    int mx;
    mx = (1 << acc_w(i)) - 1;
    if (!m_hold[i] || reset) return 0;
    if (m_exact[i] > mx) return SAT ? mx : (m_exact[i] % (mx + 1));
    return m_exact[i];
  endfunction

  function automatic bit exp_ovf(input int i);
    return m_hold[i] && !reset && (m_exact[i] > (1 << acc_w(i)) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, then compare every instance against it.
  task automatic cyc(input bit v, input int p, input bit clr, input bit ordy, input bit rst);
    in_valid   = v;
    in_product = 8'(p);
    clear      = clr;
    out_ready  = ordy;
    reset      = rst;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        m_exact[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end else if (m_hold[i]) begin
        if (ordy) begin
          m_exact[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
        end
      end else if (v) begin
        m_exact[i] += p;
        m_cnt[i]++;
        if (m_cnt[i] == count_of(i)) m_hold[i] = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready[%0d]", i), int'(rdy[i]), int'(!m_hold[i] && !reset));
      chk($sformatf("valid[%0d]", i), int'(vld[i]), int'(m_hold[i] && !reset));
      chk($sformatf("sum[%0d]", i), int'(act_sum[i]), exp_sum(i));
      chk($sformatf("ovf[%0d]", i), int'(ovf[i]), int'(exp_ovf(i)));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_exact[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
    end
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 7, 1'b0, 1'b1, 1'b1);
    chk("reset_ready", int'(rdy[0]), 0);
    chk("reset_valid", int'(vld[0]), 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("ready_after_reset", int'(rdy[0]), 1);

    // Four 225s back-to-back: 900 fits 12 bits; 9 bits wraps to 388 or saturates at 511.
    for (int k = 0; k < 4; k++) begin
      chk("pre_hold_valid", int'(vld[0]), 0);
      cyc(1'b1, 225, 1'b0, 1'b1, 1'b0);
    end
    chk("sum900", int'(s0), 900);
    chk("ovf900", int'(ovf[0]), 0);
    chk("valid900", int'(vld[0]), 1);
    chk("sum_w9", int'(s1), SAT ? 511 : 388);
    chk("ovf_w9", int'(ovf[1]), 1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("ready_after_fire", int'(rdy[0]), 1);
    chk("valid_after_fire", int'(vld[0]), 0);

    // 3+5+0+0 held for five stalled cycles while inputs keep arriving.
    cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("held_sum8", int'(s0), 8);
      chk("held_ready0", int'(rdy[0]), 0);
      cyc(1'b1, 99, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("released", int'(vld[0]), 0);

    // Clear beats a simultaneous product; the next group starts from zero.
    cyc(1'b1, 10, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 20, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 30, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    chk("after_clear_sum4", int'(s0), 4);
    chk("after_clear_ovf", int'(ovf[0]), 0);

    // Reset while holding 900 discards it.
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 225, 1'b0, 1'b0, 1'b0);
    chk("hold900", int'(s0), 900);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("reset_drop_valid", int'(vld[0]), 0);
    chk("reset_drop_sum", int'(s0), 0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 2, 1'b0, 1'b0, 1'b0);
    chk("after_reset_sum8", int'(s0), 8);

    // COUNT=1 instance: 0 and 255 with idle gaps, each result one cycle after its accept.
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("c1_valid0", int'(vld[2]), 1);
    chk("c1_sum0", int'(s2), 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 255, 1'b0, 1'b0, 1'b0);
    chk("c1_valid255", int'(vld[2]), 1);
    chk("c1_sum255", int'(s2), 255);

    // Random traffic with occasional clears, resets and back-pressure.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
